// File: rtl/imem_loader.sv
// imem_loader: fills an instruction memory from a byte stream.
// Bytes arrive over a valid/ready handshake. They are packed little-endian into
// DATA_WIDTH-bit words. Each completed word produces one single-cycle write,
// at addresses 0 .. 2**ADDR_WIDTH-1 in order. Completion is then reported on done.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start        one-cycle pulse, begins a load at address 0 (from IDLE or DONE)
//   byte_in      data byte
//   byte_valid   byte_in is valid
//   byte_ready   loader accepts a byte this cycle (LOAD only)
//   we           memory write enable, one cycle per word
//   waddr        memory write address
//   wdata        memory write data
//   busy         high in LOAD and WRITE
//   done         high once the whole memory has been written
module imem_loader #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Bytes - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [IdxW-1:0]       bidx_q, bidx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      waddr_q <= '0;
      bidx_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      bidx_q  <= bidx_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    bidx_d  = bidx_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLoad;
          waddr_d = '0;
          bidx_d  = '0;
        end
      end
      StLoad: begin
        // byte_ready is 1 throughout LOAD, so valid alone marks an accepted byte.
        if (byte_valid) begin
          wdata_d[{bidx_q, 3'b000} +: 8] = byte_in;
          if (bidx_q == LastIdx) begin
            bidx_d  = '0;
            state_d = StWrite;
          end else begin
            bidx_d = bidx_q + IdxW'(1);
          end
        end
      end
      StWrite: begin
        // Hold the address on the last word so it never wraps back to 0.
        if (waddr_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = StDone;
        end else begin
          waddr_d = waddr_q + ADDR_WIDTH'(1);
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode only registered state, so inputs have no combinational path to them.
  assign byte_ready = (state_q == StLoad);
  assign we         = (state_q == StWrite);
  assign busy       = (state_q == StLoad) || (state_q == StWrite);
  assign done       = (state_q == StDone);
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader with a write scoreboard and a memory model.
module tb_imem_loader;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;

  imem_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;
  int t0 = 0;
  bit timing_on = 1'b0;

  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;
  logic [DW-1:0]    mem[Depth];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model standing in for the instruction memory's write port.
  always @(posedge clk) if (we === 1'b1) mem[waddr] <= wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Write monitor: each we pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      chk("ready_low_in_we", byte_ready, 0);
      chk("we_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("waddr", waddr, mon_e[DW +: AW]);
        chk("wdata", wdata, mon_e[DW-1:0]);
      end
      if (timing_on) chk("we_cycle", cyc - t0, 5 * int'(waddr) + 4);
    end
  end

  // Called at a negedge; offers one byte until accepted at a following posedge.
  task automatic send_byte(input logic [7:0] b, input bit rnd, input bit st);
    bit acc = 1'b0;
    int n = 0;
    while (!acc) begin
      byte_in    = b;
      byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = st;
      acc        = byte_valid && byte_ready;
      @(negedge clk);
      n++;
      if (!acc && n > 200) begin
        chk("accept_timeout", n, 0);
        acc = 1'b1;
      end
    end
  endtask

  task automatic stream(input logic [7:0] base, input int nbytes, input bit rnd,
                        input int restart_at);
    logic [7:0] b0;
    for (int i = 0; i < nbytes; i++) begin
      b0 = base + 8'(i);
      if (i % 4 == 0 && i + 4 <= nbytes)
        exp_q.push_back({AW'(i / 4), b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
      send_byte(b0, rnd, i == restart_at);
    end
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input int lim);
    for (int i = 0; i < lim && done !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic check_mem(input string tag, input logic [7:0] base);
    logic [7:0] b0;
    for (int a = 0; a < Depth; a++) begin
      b0 = base + 8'(4 * a);
      chk(tag, mem[a], {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < Depth; a++) mem[a] = 'x;
  endtask

  initial begin
    // Reset with the clock idle: outputs must clear asynchronously.
    #3 rst = 1'b1;
    #1;
    chk("rst_we", we, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", byte_ready, 0);
    end

    // Full load, continuous stream, with exact cycle timing.
    clear_mem();
    timing_on = 1'b1;
    start_pulse();
    chk("ready_after_start", byte_ready, 1);
    stream(8'h00, 32, 1'b0, -1);
    chk("done_at_39", done, 0);
    @(negedge clk);
    chk("cycles_to_done", cyc - t0, 40);
    chk("done_at_40", done, 1);
    chk("busy_at_40", busy, 0);
    timing_on = 1'b0;
    chk("q_empty_full", exp_q.size(), 0);
    check_mem("mem_full", 8'h00);

    // Randomly stalled source: same words expected.
    clear_mem();
    start_pulse();
    stream(8'h00, 32, 1'b1, -1);
    wait_done(20);
    chk("done_stalled", done, 1);
    chk("q_empty_stalled", exp_q.size(), 0);
    check_mem("mem_stalled", 8'h00);

    // Bytes in DONE are not consumed; start mid-word is ignored.
    byte_in    = 8'hEE;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_ignores_bytes", busy, 0);
    start_pulse();
    stream(8'h40, 32, 1'b0, 2);
    wait_done(20);
    chk("done_ignored", done, 1);
    check_mem("mem_ignored", 8'h40);

    // Reset after 13 bytes, then bytes in IDLE, then a clean reload.
    start_pulse();
    stream(8'h80, 13, 1'b0, -1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", byte_ready, 0);
    chk("midrst_waddr", waddr, 0);
    chk("midrst_wdata", wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    byte_in    = 8'hEE;
    byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_no_consume", busy, 0);
    chk("q_empty_midrst", exp_q.size(), 0);
    clear_mem();
    start_pulse();
    stream(8'h60, 32, 1'b0, -1);
    wait_done(20);
    chk("done_reload", done, 1);
    check_mem("mem_reload", 8'h60);

    // Reload from DONE overwrites address 0.
    start_pulse();
    chk("done_cleared", done, 0);
    chk("busy_restart", busy, 1);
    stream(8'hA0, 4, 1'b0, -1);
    @(negedge clk);
    chk("mem0_overwrite", mem[0], 32'hA3A2A1A0);
    chk("mem1_kept", mem[1], 32'h67666564);
    chk("q_empty_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential writer that fills the CPU's instruction memory from a byte stream. It accepts bytes over a valid/ready handshake and assembles them little-endian into DATA_WIDTH-bit words. It issues one single-cycle write per word into the synchronous-write memory port at consecutive addresses 0 .. 2**ADDR_WIDTH-1, then reports completion. It is the write-side counterpart of the instruction memory read path and sits between the host byte source and the memory's write port.

## Interface
- ADDR_WIDTH, 3: word address width; depth = 2**ADDR_WIDTH words.
- DATA_WIDTH, 32: word width; must be a multiple of 8. BYTES = DATA_WIDTH/8.
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load from address 0.
- byte_in  input  8  data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- we  output  1  memory write enable, single-cycle pulse.
- waddr  output  ADDR_WIDTH  memory write address.
- wdata  output  DATA_WIDTH  memory write data.
- busy  output  1  high in LOAD and WRITE.
- done  output  1  high in DONE (full memory written).

## Operation
- States: IDLE, LOAD, WRITE, DONE. Registers: waddr, byte index bidx (0..BYTES-1), wdata assembly register.
- rst asserted (any time, including mid-load): state=IDLE, waddr=0, bidx=0, wdata=0, we=0, byte_ready=0, busy=0, done=0. Any partial word is discarded.
- IDLE: byte_ready=0. start=1 -> LOAD, waddr=0, bidx=0.
- DONE: done=1, byte_ready=0. start=1 -> LOAD, waddr=0, bidx=0, done cleared. Memory contents from the previous load are not cleared; they are overwritten.
- LOAD: byte_ready=1. A byte is accepted on a posedge with byte_valid&&byte_ready; it is written to wdata[8*bidx+7 : 8*bidx] (first byte -> bits [7:0]).
  - bidx<BYTES-1: bidx increments.
  - bidx==BYTES-1: bidx=0, state -> WRITE.
  - byte_valid low: no change. Stalls of any length are allowed.
- WRITE (exactly one cycle): we=1, byte_ready=0; waddr and wdata hold the completed word.
  - Next state: if waddr==2**ADDR_WIDTH-1 -> DONE with waddr held; else -> LOAD with waddr+1.
  - waddr never wraps to 0 except through start.
- start in LOAD or WRITE is ignored.
- byte_valid outside LOAD is ignored; no byte is consumed.
- we is high only in WRITE. busy = (state==LOAD || state==WRITE).

## Timing
- All outputs are registered or decoded from the registered state only; no combinational path from inputs to outputs.
- Cycle numbering: start sampled at edge 0; byte_ready=1 from edge 0 onward.
- Per word: at least BYTES accepting edges plus 1 WRITE cycle. Back-to-back valid bytes give a peak rate of BYTES+1 cycles per word.
- The last byte of a word is accepted at edge N. we=1 from edge N to edge N+1, and the memory captures the word at edge N+1.
- byte_ready=0 during that WRITE cycle. A source holding byte_valid=1 must keep its byte stable; it is accepted at edge N+2 or later.
- After the final WRITE, done=1 starting at the edge that ends the WRITE cycle.
- Total for the default configuration with continuous valid: 8*(4+1)=40 cycles after start to done.
- rst deassertion: the first start can be sampled at the next posedge.

## Test plan
- Reset values: assert rst mid-cycle with clk idle -> all outputs 0 immediately. Deassert rst and apply no start -> byte_ready stays 0 for 10 cycles.
- Full load, continuous stream: start, then bytes 0x00..0x1F with byte_valid held high.
  - 8 we pulses, each 5 cycles apart; waddr 0..7.
  - wdata at waddr 0 = 0x03020100, at waddr 7 = 0x1F1E1D1C.
  - done=1 and busy=0 40 cycles after start; a memory read of each address returns the written word.
- Stalled source: byte_valid toggles randomly, 50% duty.
  - Identical words and addresses to the previous test.
  - No byte is lost or duplicated; byte_ready=0 in every we cycle.
- Ignored inputs:
  - start pulsed mid-word at byte 2 -> no effect on waddr/bidx.
  - bytes driven while IDLE or DONE -> not consumed; the first word after start = the first bytes presented after start.
- Reset mid-operation: assert rst after 13 bytes -> state IDLE, no further we. A new start then reloads from waddr 0 with a clean first word.
- Reload from DONE: after a full load, start with bytes 0xA0.. -> done clears the next cycle, and address 0 is overwritten with 0xA3A2A1A0.
